data_cache_assoc: RTL and testbench



---
 rtl/data_cache_pkg.sv | 33 +++
 rtl/data_cache_align.sv | 59 +++++
 rtl/data_cache_assoc.sv | 187 ++++++++++++++++++
 tb/tb_data_cache_assoc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared definitions for the set-associative data cache.
//   - READ_WRITE access codes (bit3 = access valid)
//   - cache controller FSM state type
//   - log2_ceil helper used to derive offset/index field widths
package data_cache_pkg;

    localparam logic [3:0] RW_LB  = 4'b1000;
    localparam logic [3:0] RW_LH  = 4'b1001;
    localparam logic [3:0] RW_LW  = 4'b1010;
    localparam logic [3:0] RW_SB  = 4'b1011;
    localparam logic [3:0] RW_LBU = 4'b1100;
    localparam logic [3:0] RW_LHU = 4'b1101;
    localparam logic [3:0] RW_SH  = 4'b1110;
    localparam logic [3:0] RW_SW  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StFetch,
        StRefill
    } cache_state_e;

    // Smallest r with 2**r >= n; used for OFF_W and IDX_W.
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_cache_align.sv
// data_cache_align: combinational load extraction and store merge for one cache block.
//   read_write  : access code (selects width and sign/zero extension)
//   offset      : byte offset inside the block (naturally aligned by the pipeline)
//   block       : current block contents
//   writedata   : store data, low-aligned
//   load_data   : extended load result (0 for non-load codes)
//   store_block : block with the store bytes merged in (unchanged for non-store codes)
module data_cache_align
    import data_cache_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = 16,
    localparam int unsigned OFF_W = log2_ceil(BLOCK_BYTES),
    localparam int unsigned BLK_W = 8 * BLOCK_BYTES
) (
    input  logic [3:0]       read_write,
    input  logic [OFF_W-1:0] offset,
    input  logic [BLK_W-1:0] block,
    input  logic [31:0]      writedata,
    output logic [31:0]      load_data,
    output logic [BLK_W-1:0] store_block
);

    // Bit positions of the addressed byte, halfword and word; low offset bits are
    // masked so half/word selects stay aligned.
    logic [OFF_W+2:0] b_pos, h_pos, w_pos;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    assign b_pos  = {offset, 3'b000};
    assign h_pos  = {offset & ~OFF_W'(1), 3'b000};
    assign w_pos  = {offset & ~OFF_W'(3), 3'b000};
    assign byte_v = block[b_pos +: 8];
    assign half_v = block[h_pos +: 16];
    assign word_v = block[w_pos +: 32];

    always_comb begin
        load_data = '0;
        case (read_write)
            RW_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            RW_LH:   load_data = {{16{half_v[15]}}, half_v};
            RW_LW:   load_data = word_v;
            RW_LBU:  load_data = {24'h0, byte_v};
            RW_LHU:  load_data = {16'h0, half_v};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_block = block;
        case (read_write)
            RW_SB:   store_block[b_pos +: 8]  = writedata[7:0];
            RW_SH:   store_block[h_pos +: 16] = writedata[15:0];
            RW_SW:   store_block[w_pos +: 32] = writedata;
            default: store_block = block;
        endcase
    end

endmodule

// File: rtl/data_cache_assoc.sv
// data_cache_assoc: set-associative (1 or 2 ways), write-back, write-allocate data cache.
//   CLK, RESET_N      : clock, asynchronous active-low reset
//   READ_WRITE        : access code from the MEM stage (bit3 = valid)
//   ADDRESS/WRITEDATA : byte address and low-aligned store data
//   READDATA          : extended load result (0 unless a valid load hits)
//   BUSYWAIT          : stall request, combinational, never set on a hit in IDLE
//   MEM_READ/WRITE    : registered block-memory strobes
//   MEM_ADDRESS       : registered block address
//   MEM_WRITEDATA     : registered victim block for write-back
//   MEM_READDATA      : refill block
//   MEM_BUSYWAIT      : memory busy
module data_cache_assoc
    import data_cache_pkg::*;
#(
    parameter int unsigned SETS        = 16,
    parameter int unsigned BLOCK_BYTES = 16,
    parameter int unsigned WAYS        = 2,
    localparam int unsigned OFF_W = log2_ceil(BLOCK_BYTES),
    localparam int unsigned IDX_W = log2_ceil(SETS),
    localparam int unsigned BLK_W = 8 * BLOCK_BYTES
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [3:0]         READ_WRITE,
    input  logic [31:0]        ADDRESS,
    input  logic [31:0]        WRITEDATA,
    output logic [31:0]        READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [31-OFF_W:0]  MEM_ADDRESS,
    output logic [BLK_W-1:0]   MEM_WRITEDATA,
    input  logic [BLK_W-1:0]   MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W;

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [BLK_W-1:0] data_q  [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [SETS-1:0]  lru_q;

    cache_state_e state_q, state_d;
    logic         victim_q, victim_c, victim_sel;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic [OFF_W-1:0] addr_off;
    logic [WAYS-1:0]  hit_vec;
    logic             hit, hit_way, hit_ok, access, is_store, refill_en;
    logic [31:0]      load_data;
    logic [BLK_W-1:0] store_block;

    logic               mem_read_d, mem_write_d;
    logic [31-OFF_W:0]  mem_addr_d;
    logic [BLK_W-1:0]   mem_wdata_d;

    assign addr_tag = ADDRESS[31 -: TAG_W];
    assign addr_idx = ADDRESS[OFF_W +: IDX_W];
    assign addr_off = ADDRESS[OFF_W-1:0];
    assign access   = READ_WRITE[3];
    assign is_store = (READ_WRITE == RW_SB) || (READ_WRITE == RW_SH) || (READ_WRITE == RW_SW);

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[addr_idx][w] && (tag_q[addr_idx][w] == addr_tag);
        end
    end

    assign hit       = $onehot(hit_vec);
    assign hit_way   = (WAYS == 2) && hit_vec[WAYS-1];
    assign hit_ok    = access && (state_q == StIdle) && hit;
    assign BUSYWAIT  = access && !((state_q == StIdle) && hit);
    assign refill_en = (state_q == StFetch) && !MEM_BUSYWAIT;

    // Lowest invalid way first, otherwise the LRU way.
    always_comb begin
        victim_c = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[addr_idx][0])           victim_c = 1'b0;
            else if (!valid_q[addr_idx][WAYS-1]) victim_c = 1'b1;
            else                                 victim_c = lru_q[addr_idx];
        end
    end

    // The victim is frozen when leaving IDLE so later LRU changes cannot move it.
    assign victim_sel = (state_q == StIdle) ? victim_c : victim_q;

    data_cache_align #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_align (
        .read_write  (READ_WRITE),
        .offset      (addr_off),
        .block       (data_q[addr_idx][hit_way]),
        .writedata   (WRITEDATA),
        .load_data   (load_data),
        .store_block (store_block)
    );

    assign READDATA = (hit_ok && !is_store) ? load_data : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (access && !hit) begin
                    state_d = (valid_q[addr_idx][victim_c] && dirty_q[addr_idx][victim_c])
                              ? StWriteback : StFetch;
                end
            end
            StWriteback: if (!MEM_BUSYWAIT) state_d = StFetch;
            StFetch:     if (!MEM_BUSYWAIT) state_d = StRefill;
            StRefill:    state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Memory outputs are decoded from the next state so they are registered yet
    // already valid in the first cycle of each request state.
    always_comb begin
        mem_read_d  = (state_d == StFetch);
        mem_write_d = (state_d == StWriteback);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == StWriteback) begin
            mem_addr_d  = {tag_q[addr_idx][victim_sel], addr_idx};
            mem_wdata_d = data_q[addr_idx][victim_sel];
        end else if (state_d == StFetch) begin
            mem_addr_d  = ADDRESS[31:OFF_W];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= StIdle;
            victim_q      <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q       <= state_d;
            MEM_READ      <= mem_read_d;
            MEM_WRITE     <= mem_write_d;
            MEM_ADDRESS   <= mem_addr_d;
            MEM_WRITEDATA <= mem_wdata_d;
            if (state_q == StIdle) victim_q <= victim_c;
            if (hit_ok && is_store) dirty_q[addr_idx][hit_way] <= 1'b1;
            if (refill_en) begin
                valid_q[addr_idx][victim_q] <= 1'b1;
                dirty_q[addr_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (hit_ok && is_store) data_q[addr_idx][hit_way] <= store_block;
        if (refill_en) begin
            data_q[addr_idx][victim_q] <= MEM_READDATA;
            tag_q[addr_idx][victim_q]  <= addr_tag;
        end
    end

    // LRU bit names the way that was not most recently used.
    if (WAYS == 2) begin : g_lru
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                lru_q <= '0;
            end else if (hit_ok) begin
                lru_q[addr_idx] <= ~hit_way;
            end else if (refill_en) begin
                lru_q[addr_idx] <= ~victim_q;
            end
        end
    end else begin : g_no_lru
        assign lru_q = '0;
    end

endmodule

// File: tb/tb_data_cache_assoc.sv
// Scoreboard bench for data_cache_assoc (SETS=16, BLOCK_BYTES=16, WAYS=2).
// Reference: flat byte memory plus a per-set recency list of resident tags.
module tb_data_cache_assoc;
    import data_cache_pkg::*;

    localparam int unsigned SETS = 16;
    localparam int unsigned WAYS = 2;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [3:0]    READ_WRITE;
    logic [31:0]   ADDRESS, WRITEDATA, READDATA;
    logic          BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0]   MEM_ADDRESS;
    logic [127:0]  MEM_WRITEDATA, MEM_READDATA;

    always #5 CLK = ~CLK;

    data_cache_assoc #(
        .SETS        (SETS),
        .BLOCK_BYTES (16),
        .WAYS        (WAYS)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .READ_WRITE    (READ_WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    int total = 0;
    int bad   = 0;
    bit hold_busy = 1'b0;
    int unsigned lat;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // ---------------- reference memory ----------------
    logic [7:0]   ref_mem [int unsigned];
    logic [127:0] backing [int unsigned];

    function automatic logic [127:0] pattern();
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = 8'(i);
        return b;
    endfunction

    function automatic logic [127:0] back_get(input int unsigned ba);
        if (backing.exists(ba)) return backing[ba];
        return pattern();
    endfunction

    function automatic logic [7:0] ref_get(input int unsigned a);
        logic [127:0] blk;
        if (ref_mem.exists(a)) return ref_mem[a];
        blk = back_get(a >> 4);
        return blk[(a % 16) * 8 +: 8];
    endfunction

    function automatic logic [127:0] ref_block(input int unsigned ba);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = ref_get(ba * 16 + i);
        return b;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] code, input int unsigned a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_get(a); b1 = ref_get(a + 1); b2 = ref_get(a + 2); b3 = ref_get(a + 3);
        case (code)
            RW_LB:   return {{24{b0[7]}}, b0};
            RW_LBU:  return {24'h0, b0};
            RW_LH:   return {{16{b1[7]}}, b1, b0};
            RW_LHU:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic void ref_store(input logic [3:0] code, input int unsigned a,
                                      input logic [31:0] wd);
        int n;
        n = (code == RW_SB) ? 1 : (code == RW_SH) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[a + i] = wd[i*8 +: 8];
    endfunction

    // ---------------- cache residency model ----------------
    typedef struct {int unsigned tag; bit dirty;} line_t;
    typedef struct {bit wr; logic [27:0] addr; logic [127:0] data;} mev_t;
    line_t       sets_m [SETS][$];
    mev_t        mq [$];
    logic [31:0] rq [$];

    function automatic bit model_access(input int unsigned a, input bit st);
        int unsigned idx, tag;
        int          pos;
        line_t       l, v;
        mev_t        e;
        idx = (a >> 4) % SETS;
        tag = a >> 8;
        pos = -1;
        for (int i = 0; i < sets_m[idx].size(); i++) if (sets_m[idx][i].tag == tag) pos = i;
        if (pos >= 0) begin
            l = sets_m[idx][pos];
            sets_m[idx].delete(pos);
        end else begin
            if (sets_m[idx].size() == WAYS) begin
                v = sets_m[idx].pop_back();
                if (v.dirty) begin
                    e.wr = 1'b1;
                    e.addr = 28'((v.tag << 4) | idx);
                    e.data = ref_block((v.tag << 4) | idx);
                    mq.push_back(e);
                end
            end
            e.wr = 1'b0;
            e.addr = 28'(a >> 4);
            e.data = '0;
            mq.push_back(e);
            l.tag = tag;
            l.dirty = 1'b0;
        end
        if (st) l.dirty = 1'b1;
        sets_m[idx].push_front(l);
        return pos >= 0;
    endfunction

    function automatic bit is_st(input logic [3:0] c);
        return (c == RW_SB) || (c == RW_SH) || (c == RW_SW);
    endfunction

    // ---------------- driver ----------------
    task automatic do_access(input logic [3:0] code, input logic [31:0] a, input logic [31:0] wd);
        bit hit;
        int stall;
        READ_WRITE = code;
        ADDRESS    = a;
        WRITEDATA  = wd;
        hit = 1'b0;
        if (code[3]) begin
            hit = model_access(a, is_st(code));
            if (is_st(code)) ref_store(code, a, wd);
            else rq.push_back(exp_load(code, a));
        end
        stall = 0;
        forever begin
            @(negedge CLK);
            if (!code[3]) begin
                check("idle_busywait", BUSYWAIT, 0);
                check("idle_strobes", {MEM_READ, MEM_WRITE}, 0);
                break;
            end
            if (!BUSYWAIT) break;
            stall++;
            if (stall > 60) begin
                total++;
                bad++;
                $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, stall);
                finish_run();
            end
        end
        if (code[3]) begin
            if (hit) check("hit_stall", 32'(stall), 0);
            else     check("miss_stall", (stall >= 2) ? 1 : 0, 1);
        end
        @(posedge CLK);
        #1;
    endtask

    // ---------------- memory responder + scoreboard monitor ----------------
    initial begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        lat = $urandom_range(3);
        forever begin
            @(negedge CLK);
            MEM_READDATA = back_get(32'(MEM_ADDRESS));
            if (!RESET_N) begin
                MEM_BUSYWAIT = 1'b0;
            end else if (MEM_READ || MEM_WRITE) begin
                check("strobe_exclusive", MEM_READ && MEM_WRITE, 0);
                if (mq.size() == 0) begin
                    check("mem_request_expected", mq.size(), 1);
                    MEM_BUSYWAIT = hold_busy;
                end else begin
                    check("mem_kind", MEM_WRITE, mq[0].wr);
                    check("mem_address", MEM_ADDRESS, mq[0].addr);
                    if (MEM_WRITE) check("wb_data", MEM_WRITEDATA, mq[0].data);
                    if (hold_busy) begin
                        MEM_BUSYWAIT = 1'b1;
                    end else if (lat == 0) begin
                        MEM_BUSYWAIT = 1'b0;
                        if (MEM_WRITE) backing[32'(MEM_ADDRESS)] = MEM_WRITEDATA;
                        void'(mq.pop_front());
                        lat = $urandom_range(3);
                    end else begin
                        MEM_BUSYWAIT = 1'b1;
                        lat--;
                    end
                end
            end else begin
                MEM_BUSYWAIT = 1'b0;
            end
            if (RESET_N && READ_WRITE[3] && !BUSYWAIT && !is_st(READ_WRITE)) begin
                if (rq.size() == 0) check("load_expected", rq.size(), 1);
                else check("readdata", READDATA, rq.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  codes [8];
        logic [3:0]  c;
        logic [31:0] a;
        codes = '{RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU, RW_SB, RW_SH, RW_SW};

        RESET_N = 1'b0; READ_WRITE = 4'b0000; ADDRESS = '0; WRITEDATA = '0;
        #12;
        check("rst_busywait", BUSYWAIT, 0);
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_write", MEM_WRITE, 0);
        check("rst_mem_address", MEM_ADDRESS, 0);
        check("rst_mem_writedata", MEM_WRITEDATA, 0);
        check("rst_readdata", READDATA, 0);
        #5 RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Directed sequence
        do_access(RW_LW, 32'h40, 0);
        do_access(RW_SB, 32'h41, 32'h000000AB);
        do_access(RW_LBU, 32'h41, 0);
        do_access(RW_LB, 32'h41, 0);
        do_access(RW_SH, 32'h44, 32'h00008001);
        do_access(RW_LH, 32'h44, 0);
        do_access(RW_LHU, 32'h44, 0);
        do_access(4'b0000, 32'h140, 0);
        do_access(4'b0101, 32'h12345678, 0);
        do_access(RW_LW, 32'h140, 0);
        do_access(RW_LW, 32'h40, 0);
        do_access(RW_LW, 32'h240, 0);
        do_access(RW_LW, 32'h140, 0);

        // Reset while a fetch is held busy by memory
        hold_busy  = 1'b1;
        READ_WRITE = RW_LW;
        ADDRESS    = 32'h340;
        void'(model_access(32'h340, 1'b0));
        rq.push_back(exp_load(RW_LW, 32'h340));
        repeat (3) @(negedge CLK);
        check("held_fetch_read", MEM_READ, 1);
        check("held_fetch_addr", MEM_ADDRESS, 28'h34);
        #2 RESET_N = 1'b0;
        #1;
        check("rst_drop_read", MEM_READ, 0);
        check("rst_drop_addr", MEM_ADDRESS, 0);
        READ_WRITE = 4'b0000;
        mq.delete();
        rq.delete();
        ref_mem.delete();
        for (int s = 0; s < SETS; s++) sets_m[s].delete();
        hold_busy = 1'b0;
        #1;
        check("rst_busy_idle", BUSYWAIT, 0);
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        @(posedge CLK); #1;
        do_access(RW_LW, 32'h40, 0);
        do_access(RW_LBU, 32'h41, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(9) < 2) begin
                c = {1'b0, 3'($urandom)};
            end else begin
                c = codes[$urandom_range(7)];
            end
            a = $urandom & 32'h3FF;
            if ($urandom_range(7) == 0) a = a | 32'hABC00000;
            if (c == RW_LH || c == RW_LHU || c == RW_SH) a = a & ~32'h1;
            if (c == RW_LW || c == RW_SW) a = a & ~32'h3;
            do_access(c, a, $urandom);
        end

        READ_WRITE = 4'b0000;
        repeat (4) @(negedge CLK);
        check("drain_mem_queue", mq.size(), 0);
        check("drain_load_queue", rq.size(), 0);
        finish_run();
    end

endmodule
